// File: rtl/altera_nios2_qsys_mwb6kynm_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares the single debug RAM port between JTAG debug
// commands and the CPU debug-slave port, with round-robin arbitration.
module altera_nios2_qsys_mwb6kynm_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // state     | meaning
  // S_IDLE    | RAM port free; pick a winner and load ram_* for next cycle
  // S_ISSUE   | ram_en high for one cycle; CPU winner sees cpu_gnt here
  // S_RD_WAIT | ram_rdata valid; capture into MonDReg or cpu_rdata
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jop_ao_q, jop_ao_d;
  logic                jop_rd_q, jop_rd_d;
  logic                jop_inc_q, jop_inc_d;
  logic [DATA_W-1:0]   jwdata_q, jwdata_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                mon_ready_q, mon_ready_d;
  logic                mon_err_q, mon_err_d;
  logic                last_gnt_cpu_q, last_gnt_cpu_d;
  logic                cur_cpu_q, cur_cpu_d;
  logic                cur_rd_q, cur_rd_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;

  logic                any_strobe;
  logic                jtag_req;
  logic                jtag_done;
  logic                pick_cpu;
  logic                unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // An address-only command holds jtag_pend for one cycle but never needs the RAM.
  assign jtag_req   = jtag_pend_q & ~jop_ao_q;
  assign unused_jdo = ^jdo[36:DATA_W];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    jtag_pend_d    = jtag_pend_q;
    jop_ao_d       = jop_ao_q;
    jop_rd_d       = jop_rd_q;
    jop_inc_d      = jop_inc_q;
    jwdata_d       = jwdata_q;
    mon_dreg_d     = mon_dreg_q;
    mon_ready_d    = mon_ready_q;
    mon_err_d      = mon_err_q;
    last_gnt_cpu_d = last_gnt_cpu_q;
    cur_cpu_d      = cur_cpu_q;
    cur_rd_d       = cur_rd_q;
    ram_en_d       = 1'b0;
    ram_we_d       = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    cpu_gnt_d      = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_rvalid_d   = 1'b0;
    jtag_done      = 1'b0;
    pick_cpu       = 1'b0;

    if (any_strobe) begin
      if (jtag_pend_q) begin
        mon_err_d = 1'b1;
      end else begin
        jtag_pend_d = 1'b1;
        mon_ready_d = 1'b0;
        if (take_action_ocimem_a) begin
          addr_d    = jdo[ADDR_W+1:2];
          mon_err_d = 1'b0;
          jop_ao_d  = ~jdo[37];
          jop_rd_d  = jdo[37];
          jop_inc_d = 1'b0;
        end else if (take_action_ocimem_b) begin
          jop_ao_d  = 1'b0;
          jop_rd_d  = 1'b0;
          jop_inc_d = 1'b1;
          jwdata_d  = jdo[DATA_W-1:0];
        end else begin
          jop_ao_d  = 1'b0;
          jop_rd_d  = 1'b1;
          jop_inc_d = 1'b1;
        end
      end
    end

    if (jtag_pend_q && jop_ao_q) begin
      jtag_done = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (jtag_req || cpu_req) begin
          // On a tie the requester that did not win last time goes first.
          pick_cpu       = cpu_req && (!jtag_req || !last_gnt_cpu_q);
          last_gnt_cpu_d = pick_cpu;
          cur_cpu_d      = pick_cpu;
          ram_en_d       = 1'b1;
          state_d        = S_ISSUE;
          if (pick_cpu) begin
            ram_we_d    = cpu_we;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            cur_rd_d    = ~cpu_we;
            cpu_gnt_d   = 1'b1;
          end else begin
            ram_we_d    = ~jop_rd_q;
            ram_addr_d  = addr_q;
            ram_wdata_d = jwdata_q;
            cur_rd_d    = jop_rd_q;
          end
        end
      end
      S_ISSUE: begin
        if (cur_rd_q) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_IDLE;
          if (!cur_cpu_q) begin
            jtag_done = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        state_d = S_IDLE;
        if (cur_cpu_q) begin
          cpu_rdata_d  = ram_rdata;
          cpu_rvalid_d = 1'b1;
        end else begin
          mon_dreg_d = ram_rdata;
          jtag_done  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (jtag_done) begin
      jtag_pend_d = 1'b0;
      mon_ready_d = 1'b1;
      if (jop_inc_q) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      jtag_pend_q    <= 1'b0;
      jop_ao_q       <= 1'b0;
      jop_rd_q       <= 1'b0;
      jop_inc_q      <= 1'b0;
      jwdata_q       <= '0;
      mon_dreg_q     <= '0;
      mon_ready_q    <= 1'b0;
      mon_err_q      <= 1'b0;
      last_gnt_cpu_q <= 1'b1;
      cur_cpu_q      <= 1'b0;
      cur_rd_q       <= 1'b0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      cpu_gnt_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_rvalid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      jtag_pend_q    <= jtag_pend_d;
      jop_ao_q       <= jop_ao_d;
      jop_rd_q       <= jop_rd_d;
      jop_inc_q      <= jop_inc_d;
      jwdata_q       <= jwdata_d;
      mon_dreg_q     <= mon_dreg_d;
      mon_ready_q    <= mon_ready_d;
      mon_err_q      <= mon_err_d;
      last_gnt_cpu_q <= last_gnt_cpu_d;
      cur_cpu_q      <= cur_cpu_d;
      cur_rd_q       <= cur_rd_d;
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      cpu_gnt_q      <= cpu_gnt_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = mon_ready_q;
  assign monitor_error = mon_err_q;
  assign cpu_gnt       = cpu_gnt_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_rvalid    = cpu_rvalid_q;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule
